jc2_ctrl: RTL and testbench

Button-driven run controller for the jc2 Johnson-counter display. Takes the three raw active-low pushbuttons (goLeft, goRight, stop), synchronises and edge-detects them, arbitrates simultaneous presses, and runs a direction FSM with a step prescaler. The prescaler sequences a WIDTH-bit Johnson register whose value drives the LEDs. Sits between the board buttons and the LED pins.

---
 rtl/jc2_pkg.sv | 12 +
 rtl/jc2_btn_sync.sv | 24 ++
 rtl/jc2_ctrl.sv | 53 +++++
 tb/tb_jc2_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/jc2_pkg.sv
// jc2_pkg: shared state encoding, button level and prescaler sizing for jc2_ctrl
package jc2_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LEFT  = 2'b01,
      RIGHT = 2'b10
   } stateT;
   localparam logic ACTIVE = 1'b0;
   function automatic int cntWidth(input int div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction
endpackage

// File: rtl/jc2_btn_sync.sv
// jc2_btn_sync: synchronises one active-low button and emits a one-cycle press per falling edge
module jc2_btn_sync
   import jc2_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);
   logic [SYNC_STAGES-1:0] sync;
   logic prev;
   // shift the raw level through the synchroniser; prev remembers the last synced level
   always_ff @(posedge clk)
      if (rst) begin
         sync <= '1;
         prev <= 1'b1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], btn};
         prev <= sync[SYNC_STAGES-1];
      end
   assign press = (prev != ACTIVE) && (sync[SYNC_STAGES-1] == ACTIVE);
endmodule

// File: rtl/jc2_ctrl.sv
// jc2_ctrl: button-driven direction FSM with step prescaler sequencing a Johnson LED register
module jc2_ctrl
   import jc2_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int DIV         = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             goLeft,
   input  logic             goRight,
   input  logic             stop,
   output logic [WIDTH-1:0] q,
   output logic             running,
   output logic             dir,
   output logic             step
);
   localparam int CW = cntWidth(DIV);
   logic pressLeft, pressRight, pressStop, actLeft, actRight;
   logic [CW-1:0] cnt;
   stateT state, nextState;

   jc2_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) uLeft  (.clk(clk), .rst(rst), .btn(goLeft),  .press(pressLeft));
   jc2_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) uRight (.clk(clk), .rst(rst), .btn(goRight), .press(pressRight));
   jc2_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) uStop  (.clk(clk), .rst(rst), .btn(stop),    .press(pressStop));

   assign actLeft  = pressLeft & ~pressStop;
   assign actRight = pressRight & ~pressStop & ~pressLeft;
   assign running  = (state == LEFT) || (state == RIGHT);
   assign step     = running && (cnt == CW'(DIV - 1));

   // stop beats goLeft beats goRight; the illegal encoding falls back to IDLE
   always_comb
      nextState = pressStop ? IDLE : actLeft ? LEFT : actRight ? RIGHT : running ? state : IDLE;

   // state register
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= nextState;

   // prescaler restarts on any direction entry, Johnson register advances on step, dir tracks entries
   always_ff @(posedge clk)
      if (rst) begin
         cnt <= '0;
         q   <= '0;
         dir <= 1'b0;
      end else begin
         cnt <= (nextState == IDLE || actLeft || actRight || step) ? '0 : cnt + 1'b1;
         if (step) q <= (state == LEFT) ? {q[WIDTH-2:0], ~q[WIDTH-1]} : {~q[0], q[WIDTH-1:1]};
         dir <= actLeft ? 1'b1 : actRight ? 1'b0 : dir;
      end
endmodule

// File: tb/tb_jc2_ctrl.sv
// tb_jc2_ctrl: directed vectors plus randomized buttons checked against a Johnson-position model
module tb_jc2_ctrl;
   localparam int W = 4;
   localparam int S = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic goLeft = 1'b1, goRight = 1'b1, stop = 1'b1;
   logic [W-1:0] qA, qB;
   logic runA, runB, dirA, dirB, stepA, stepB;

   always #5 clk = ~clk;

   jc2_ctrl #(.WIDTH(W), .DIV(4), .SYNC_STAGES(S)) dutA (
      .clk(clk), .rst(rst), .goLeft(goLeft), .goRight(goRight), .stop(stop),
      .q(qA), .running(runA), .dir(dirA), .step(stepA));
   jc2_ctrl #(.WIDTH(W), .DIV(1), .SYNC_STAGES(S)) dutB (
      .clk(clk), .rst(rst), .goLeft(goLeft), .goRight(goRight), .stop(stop),
      .q(qB), .running(runB), .dir(dirB), .step(stepB));

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic r, gl, gr, st;
      int ticks;
      logic [3:0] q;
      logic run, dir, stp;
   } vecT;
   vecT vecs[22];

   // model: mode 0 idle, 1 left, 2 right; pos is the index along the 2W-long Johnson cycle
   int mMode[2], mPhase[2], mPos[2], mDir[2];
   logic [2:0] hist[$];

   function automatic int jq(int p);
      return (p <= W) ? (1 << p) - 1 : ((1 << W) - 1) ^ ((1 << (p - W)) - 1);
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic modelEdge();
      logic [2:0] pr;
      int d;
      bit stp, entered;
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            mMode[i] = 0; mPhase[i] = 0; mPos[i] = 0; mDir[i] = 0;
         end
         hist = {};
         repeat (S + 1) hist.push_front(3'b111);
      end else begin
         pr = hist[S] & ~hist[S-1];
         for (int i = 0; i < 2; i++) begin
            d = (i == 0) ? 4 : 1;
            stp = (mMode[i] != 0) && (mPhase[i] == d - 1);
            entered = 0;
            if (stp) mPos[i] = (mMode[i] == 1) ? (mPos[i] + 1) % (2 * W) : (mPos[i] + 2 * W - 1) % (2 * W);
            if (pr[2]) mMode[i] = 0;
            else if (pr[1]) begin mMode[i] = 1; mDir[i] = 1; entered = 1; end
            else if (pr[0]) begin mMode[i] = 2; mDir[i] = 0; entered = 1; end
            mPhase[i] = (entered || mMode[i] == 0) ? 0 : (mPhase[i] + 1) % d;
         end
         hist.push_front({stop, goLeft, goRight});
         void'(hist.pop_back());
      end
   endtask

   task automatic tick();
      int d;
      @(posedge clk);
      modelEdge();
      #1;
      for (int i = 0; i < 2; i++) begin
         d = (i == 0) ? 4 : 1;
         check($sformatf("model%0d.q", i), (i == 0) ? int'(qA) : int'(qB), jq(mPos[i]));
         check($sformatf("model%0d.running", i), (i == 0) ? int'(runA) : int'(runB), int'(mMode[i] != 0));
         check($sformatf("model%0d.dir", i), (i == 0) ? int'(dirA) : int'(dirB), mDir[i]);
         check($sformatf("model%0d.step", i), (i == 0) ? int'(stepA) : int'(stepB),
               int'(mMode[i] != 0 && mPhase[i] == d - 1));
      end
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 50, 4'b0000, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1,  3, 4'b0000, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1,  3, 4'b0000, 1'b1, 1'b1, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1,  1, 4'b0001, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1,  4, 4'b0011, 1'b1, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1,  4, 4'b0111, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1,  3, 4'b0111, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1,  4, 4'b0011, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1,  4, 4'b0001, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1,  4, 4'b0000, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1,  4, 4'b1000, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0,  3, 4'b1000, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 10, 4'b1000, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 16, 4'b0011, 1'b1, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0,  2, 4'b0011, 1'b1, 1'b1, 1'b1};
      vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1,  1, 4'b0111, 1'b0, 1'b1, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b1,  8, 4'b0111, 1'b0, 1'b1, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 11, 4'b1110, 1'b1, 1'b1, 1'b0};
      vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1,  3, 4'b1110, 1'b1, 1'b0, 1'b0};
      vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b1,  1, 4'b0000, 1'b0, 1'b0, 1'b0};
      vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b1,  3, 4'b0000, 1'b1, 1'b0, 1'b0};
      vecs[21] = '{1'b0, 1'b1, 1'b1, 1'b1,  4, 4'b1000, 1'b1, 1'b0, 1'b0};
      repeat (S + 1) hist.push_front(3'b111);

      rst = 1'b1;
      repeat (2) tick();
      for (int n = 0; n < 22; n++) begin
         rst = vecs[n].r; goLeft = vecs[n].gl; goRight = vecs[n].gr; stop = vecs[n].st;
         repeat (vecs[n].ticks) tick();
         check($sformatf("vec%0d.q", n), int'(qA), int'(vecs[n].q));
         check($sformatf("vec%0d.running", n), int'(runA), int'(vecs[n].run));
         check($sformatf("vec%0d.dir", n), int'(dirA), int'(vecs[n].dir));
         check($sformatf("vec%0d.step", n), int'(stepA), int'(vecs[n].stp));
      end

      rst = 1'b1; goLeft = 1'b1; goRight = 1'b1; stop = 1'b1;
      tick();
      check("div1.reset.q", int'(qB), 0);
      rst = 1'b0; goLeft = 1'b0;
      repeat (3) tick();
      check("div1.entry.running", int'(runB), 1);
      check("div1.entry.step", int'(stepB), 1);
      check("div1.entry.q", int'(qB), 0);
      tick();
      check("div1.step1.q", int'(qB), 4'b0001);
      tick();
      check("div1.step2.q", int'(qB), 4'b0011);
      check("div1.step2.step", int'(stepB), 1);
      goLeft = 1'b1;

      repeat (200) begin
         rst = ($urandom_range(0, 39) == 0);
         goLeft  = ($urandom_range(0, 2) != 0);
         goRight = ($urandom_range(0, 2) != 0);
         stop    = ($urandom_range(0, 4) != 0);
         repeat ($urandom_range(1, 12)) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
